m_cq_seg_reader: RTL and testbench
==================================

# m_cq_seg_reader

Read-side consumer for the circular queue. When the queue is not empty, it pops one byte at a paced rate and shifts the byte into a 16-bit display buffer. It drives a multiplexed, active-low, 4-digit 7-segment display with the buffer as four hex digits. It is the drain end of the queue path in the general bench, paired with the queue's writer.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit-scan step; must be ≥2.
- `HOLD_TICKS`, default 25000000: idle cycles after each pop before the next pop is allowed; must be ≥1.
- `clk` input, 1 bit: single clock; all logic is on the rising edge.
- `rst_n` input, 1 bit: reset is synchronous and active-low.
- `i_empty` input, 1 bit: queue empty flag.
- `o_rd_en` output, 1 bit: queue read strobe, one cycle per pop.
- `i_rd_data` input, 8 bits: queue read data, valid in the cycle after the cycle `o_rd_en` is high.
- `i_clear` input, 1 bit: synchronous clear of the display buffer.
- `o_busy` output, 1 bit: high when the FSM is not in IDLE.
- `o_pop_cnt` output, 8 bits: number of bytes popped, modulo 256.
- `o_an` output, 4 bits: digit enables, active-low; bit 0 is the least-significant digit.
- `o_seg` output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.

## Operation
- FSM states: IDLE, RD, CAP, HOLD.
  - IDLE → RD when `i_empty`=0; otherwise stay in IDLE.
  - RD → CAP unconditionally. `o_rd_en` = (state==RD) and is decoded from the state register.
  - CAP → HOLD unconditionally. In CAP: `buf` <= {`buf[7:0]`, `i_rd_data`}, `o_pop_cnt` increments, hold counter <= 0.
  - HOLD → IDLE when the hold counter reaches `HOLD_TICKS`-1; otherwise the counter increments.
- `i_empty` is sampled only in IDLE. A pop that has been issued always completes to CAP.
- `i_clear` with no capture in the same cycle: `buf` <= 16'h0000.
- `i_clear` in the CAP cycle: `buf` <= {8'h00, `i_rd_data`}.
- `i_clear` never changes the FSM state or `o_pop_cnt`.
- `o_pop_cnt` wraps from 8'hFF to 8'h00.
- Scan:
  - Scan counter runs 0..`SCAN_DIV`-1.
  - At the terminal count, the digit index `idx` <= `idx`+1 (mod 4).
  - Each cycle: `o_an` <= ~(4'b0001 << `idx`) and `o_seg` <= hex(`buf[4*idx+3:4*idx]`).
- Hex patterns, values 0..F: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E. Blank = 7F.

## Timing
- Reset values:
  - state IDLE, `o_rd_en`=0, `o_busy`=0, `o_pop_cnt`=0.
  - `buf`=0, `idx`=0, scan counter 0, hold counter 0.
  - `o_an`=4'b1110, `o_seg`=7'h40.
- Pop handshake:
  - Edge E0 samples `i_empty`=0 in IDLE. `o_rd_en` is high for exactly the cycle E0..E1.
  - The queue samples the strobe at E1 and presents data in E1..E2.
  - The capture happens at E2. `o_seg` reflects the new buffer at E3 when the affected digit is currently selected.
- Back-to-back pops with the queue never empty: `o_rd_en` pulses exactly `HOLD_TICKS`+3 cycles apart.
- `i_empty` is ignored in RD, CAP and HOLD. The queue guarantees `i_rd_data` validity only for a strobe issued while it was not empty.
- Digit rotation: each digit is active for `SCAN_DIV` cycles. Index order is 0,1,2,3,0…
- `o_an` and `o_seg` change together, one cycle after an `idx` change.
- Reset has priority over everything. Asserting `rst_n`=0 in RD or CAP abandons the pop with no capture and no count. The next cycle shows the reset values.

## Configuration
- Macro: `CQ_SEG_LZB_EN`.
- Defined: leading-zero blanking. Digits above the highest nonzero nibble of `buf` output 7'h7F. Digit 0 is never blanked, so `buf`=0 shows a single "0" on digit 0.
- Undefined: all four digits always show their hex value, including leading zeros.

## Test plan
- Bench parameters: `SCAN_DIV`=4, `HOLD_TICKS`=3. Both builds.
- Reset with `rst_n` low for 2 cycles, then `i_empty`=1 for 20 cycles → `o_rd_en`=0, `o_busy`=0, `o_pop_cnt`=0, and `o_an` rotates 1110→1101→1011→0111 every 4 cycles.
  - Without the macro: `o_seg`=40 on every digit.
  - With the macro: digits 1–3 show `o_seg`=7F.
- Queue holds A5 then 3C, `i_empty` falls at E0 → strobes at E0 and E0+6, `buf`=A53C, `o_pop_cnt`=2.
  - Digits 0..3 show 46, 30, 12, 08.
- `i_clear` asserted in the CAP cycle of byte 7E, with prior `buf`=1234 → `buf`=007E, `o_pop_cnt` increments.
  - With the macro: digits 2 and 3 show 7F.
- `rst_n` low during RD → no capture, `o_pop_cnt` stays 0, all outputs return to their reset values the next cycle.
- 256 consecutive pops → `o_pop_cnt` wraps to 00, and `buf` equals the last two bytes popped.

Source files
------------

// File: rtl/m_cq_seg_reader.sv
// Paced queue drain into a 16-bit buffer shown on a muxed 4-digit 7-seg display.
// Optional leading-zero blanking when CQ_SEG_LZB_EN is defined.
module m_cq_seg_reader #(
  parameter int SCAN_DIV   = 50000,
  parameter int HOLD_TICKS = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_empty,
  output logic       o_rd_en,
  input  logic [7:0] i_rd_data,
  input  logic       i_clear,
  output logic       o_busy,
  output logic [7:0] o_pop_cnt,
  output logic [3:0] o_an,
  output logic [6:0] o_seg
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {IDLE, RD, CAP, HOLD} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0]   dbuf_q, dbuf_d;
  logic [7:0]    pop_q, pop_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    nib;
  logic          blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    hex7 = 7'h7F;
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop_d   = pop_q;
    unique case (state_q)
      IDLE: if (!i_empty) state_d = RD;
      RD:   state_d = CAP;
      CAP: begin
        state_d = HOLD;
        pop_d   = pop_q + 8'd1;
        hold_d  = '0;
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) state_d = IDLE;
        else hold_d = hold_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear coinciding with a capture keeps the freshly captured byte.
  always_comb begin
    dbuf_d = dbuf_q;
    if (state_q == CAP)
      dbuf_d = i_clear ? {8'h00, i_rd_data} : {dbuf_q[7:0], i_rd_data};
    else if (i_clear)
      dbuf_d = '0;
  end

  always_comb begin
    scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
    idx_d  = (scan_q == SCAN_LAST) ? idx_q + 2'd1 : idx_q;
    nib    = 4'h0;
    unique case (idx_q)
      2'd0: nib = dbuf_q[3:0];
      2'd1: nib = dbuf_q[7:4];
      2'd2: nib = dbuf_q[11:8];
      2'd3: nib = dbuf_q[15:12];
      default: nib = 4'h0;
    endcase
`ifdef CQ_SEG_LZB_EN
    unique case (idx_q)
      2'd1: blank = (dbuf_q[15:4] == 12'h000);
      2'd2: blank = (dbuf_q[15:8] == 8'h00);
      2'd3: blank = (dbuf_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? 7'h7F : hex7(nib);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      dbuf_q  <= '0;
      pop_q   <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      an_q    <= 4'b1110;
      seg_q   <= 7'h40;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      dbuf_q  <= dbuf_d;
      pop_q   <= pop_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign o_rd_en   = (state_q == RD);
  assign o_busy    = (state_q != IDLE);
  assign o_pop_cnt = pop_q;
  assign o_an      = an_q;
  assign o_seg     = seg_q;

endmodule

// File: tb/tb_m_cq_seg_reader.sv
// Bench for m_cq_seg_reader: vector table, directed corners, random run vs model.
// Build with or without CQ_SEG_LZB_EN.
module tb_m_cq_seg_reader;

  localparam int SD = 4;
  localparam int HT = 3;
`ifdef CQ_SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_empty = 1'b1;
  logic       o_rd_en;
  logic [7:0] i_rd_data = 8'h00;
  logic       i_clear = 1'b0;
  logic       o_busy;
  logic [7:0] o_pop_cnt;
  logic [3:0] o_an;
  logic [6:0] o_seg;

  m_cq_seg_reader #(.SCAN_DIV(SD), .HOLD_TICKS(HT)) dut (
    .clk(clk), .rst_n(rst_n), .i_empty(i_empty), .o_rd_en(o_rd_en),
    .i_rd_data(i_rd_data), .i_clear(i_clear), .o_busy(o_busy),
    .o_pop_cnt(o_pop_cnt), .o_an(o_an), .o_seg(o_seg)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
    7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] an_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  int checks = 0;
  int errors = 0;

  // queue emulation and reference model state
  logic [7:0] fifo[$];
  bit         force_empty = 1'b1;
  bit         clr_on_cap = 1'b0;
  int         edge_no = 0;
  int         next_ok = 0;
  int         scan_k = 0;
  int         mcnt = 0;
  bit         pend = 1'b0;
  bit         exp_rd = 1'b0;
  bit         was_rst = 1'b1;
  logic [15:0] mbuf = 16'h0;
  logic [15:0] mbuf_prev = 16'h0;

  typedef struct {
    bit         rst;
    bit         emp;
    bit         rd;
    bit         busy;
    logic [7:0] cnt;
    logic [3:0] an;
    logic [6:0] seg;
  } vec_t;
  vec_t vt [22];

  task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(logic [15:0] v, int d);
    logic [15:0] hi;
    hi = v >> (4 * d);
    if (LZB && d > 0 && hi == 16'h0) return 7'h7F;
    return hex_tbl[hi[3:0]];
  endfunction

  task automatic tick();
    bit r, e, c, drd, rd_before;
    logic [7:0] d;
    logic [3:0] ean;
    int idx;
    if (clr_on_cap) i_clear = pend;
    i_empty = force_empty || (fifo.size() == 0);
    r = rst_n; e = i_empty; c = i_clear; d = i_rd_data;
    drd = o_rd_en; rd_before = exp_rd;
    @(posedge clk);
    edge_no++;
    mbuf_prev = mbuf;
    was_rst = !r;
    if (!r) begin
      exp_rd = 0; pend = 0; next_ok = edge_no + 1;
      mbuf = 16'h0; mcnt = 0; scan_k = 0;
    end else begin
      if (pend) begin
        mbuf = c ? {8'h00, d} : {mbuf[7:0], d};
        mcnt++;
      end else if (c) begin
        mbuf = 16'h0;
      end
      pend = rd_before;
      exp_rd = (edge_no >= next_ok) && !e;
      if (exp_rd) next_ok = edge_no + HT + 3;
      scan_k++;
    end
    #1;
    if (drd && fifo.size() > 0) i_rd_data = fifo.pop_front();
    @(negedge clk);
    check("rd_en", o_rd_en, exp_rd);
    check("busy", o_busy, (edge_no + 1 < next_ok));
    check("pop_cnt", o_pop_cnt, mcnt[7:0]);
    if (was_rst) begin
      check("an_rst", o_an, 4'b1110);
      check("seg_rst", o_seg, 7'h40);
    end else begin
      idx = ((scan_k - 1) / SD) % 4;
      ean = ~(4'b0001 << idx);
      check("an", o_an, ean);
      check("seg", o_seg, seg_of(mbuf_prev, idx));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_pops(int n, int budget, string nm);
    int t = 0;
    while (mcnt < n && t < budget) begin
      tick();
      t++;
    end
    check(nm, (mcnt >= n), 1'b1);
  endtask

  task automatic disp_check(string nm, logic [6:0] e0, logic [6:0] e1,
                            logic [6:0] e2, logic [6:0] e3);
    for (int t = 0; t < 4 * SD; t++) begin
      tick();
      case (o_an)
        4'b1110: check({nm, "_d0"}, o_seg, e0);
        4'b1101: check({nm, "_d1"}, o_seg, e1);
        4'b1011: check({nm, "_d2"}, o_seg, e2);
        4'b0111: check({nm, "_d3"}, o_seg, e3);
        default: check({nm, "_an"}, o_an, 4'b1110);
      endcase
    end
  endtask

  initial begin
    int strobes[$];
    logic [7:0] bytes [256];
    logic [15:0] v;
    logic [6:0] z;
    z = LZB ? 7'h7F : 7'h40;

    for (int i = 0; i < 22; i++) begin
      int dg;
      dg = (i < 2) ? 0 : ((i - 2) / 4) % 4;
      vt[i].rst  = (i >= 2);
      vt[i].emp  = 1'b1;
      vt[i].rd   = 1'b0;
      vt[i].busy = 1'b0;
      vt[i].cnt  = 8'h00;
      vt[i].an   = an_seq[dg];
      vt[i].seg  = (dg == 0) ? 7'h40 : z;
    end

    // idle after reset: rotation and zero display
    for (int i = 0; i < 22; i++) begin
      rst_n = vt[i].rst;
      force_empty = vt[i].emp;
      i_clear = 1'b0;
      tick();
      check("vec_rd", o_rd_en, vt[i].rd);
      check("vec_busy", o_busy, vt[i].busy);
      check("vec_cnt", o_pop_cnt, vt[i].cnt);
      check("vec_an", o_an, vt[i].an);
      check("vec_seg", o_seg, vt[i].seg);
    end

    // two pops, strobes 6 cycles apart
    fifo.push_back(8'hA5);
    fifo.push_back(8'h3C);
    force_empty = 1'b0;
    for (int t = 0; t < 14; t++) begin
      tick();
      if (o_rd_en) strobes.push_back(t);
    end
    check("strobe_n", strobes.size(), 2);
    if (strobes.size() == 2) begin
      check("strobe0", strobes[0], 0);
      check("strobe1", strobes[1], 6);
    end
    check("cnt_two", o_pop_cnt, 8'd2);
    disp_check("a53c", 7'h46, 7'h30, 7'h12, 7'h08);

    // clear coincident with capture
    do_reset();
    fifo.push_back(8'h12);
    fifo.push_back(8'h34);
    wait_pops(2, 40, "pop_1234");
    disp_check("b1234", 7'h19, 7'h30, 7'h24, 7'h79);
    fifo.push_back(8'h7E);
    clr_on_cap = 1'b1;
    wait_pops(3, 40, "pop_7e");
    clr_on_cap = 1'b0;
    i_clear = 1'b0;
    check("cnt_clr", o_pop_cnt, 8'd3);
    disp_check("b007e", 7'h06, 7'h78, z, z);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    disp_check("bclr", 7'h40, z, z, z);

    // reset while in RD abandons the pop
    do_reset();
    fifo.push_back(8'h55);
    force_empty = 1'b0;
    tick();
    check("rd_pre_rst", o_rd_en, 1'b1);
    force_empty = 1'b1;
    rst_n = 1'b0;
    tick();
    check("rst_rd", o_rd_en, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_cnt", o_pop_cnt, 8'd0);
    check("rst_an", o_an, 4'b1110);
    check("rst_seg", o_seg, 7'h40);
    rst_n = 1'b1;
    fifo.delete();
    for (int t = 0; t < 6; t++) tick();
    check("rst_cnt_hold", o_pop_cnt, 8'd0);
    disp_check("rst_buf", 7'h40, z, z, z);

    // 256 pops wrap the counter
    do_reset();
    for (int i = 0; i < 256; i++) begin
      bytes[i] = 8'($urandom);
      fifo.push_back(bytes[i]);
    end
    force_empty = 1'b0;
    wait_pops(256, 256 * (HT + 3) + 20, "pop_256");
    check("cnt_wrap", o_pop_cnt, 8'd0);
    v = {bytes[254], bytes[255]};
    disp_check("last2", seg_of(v, 0), seg_of(v, 1), seg_of(v, 2), seg_of(v, 3));

    // random traffic against the model
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(7) == 0) fifo.push_back(8'($urandom));
      i_clear = ($urandom_range(15) == 0);
      rst_n = ($urandom_range(199) != 0);
      force_empty = 1'b0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
